// File: rtl/local_flit_injector_pkg.sv
// Shared widths, flit encodings and flit bus types for the PE-side local port injector.
package local_flit_injector_pkg;

    localparam int XWidth        = 4;
    localparam int YWidth        = 4;
    localparam int PktWidth      = 4;
    localparam int VcWidth       = 2;
    localparam int FlitWidth     = 32;
    localparam int FlitDataWidth = FlitWidth - 2;
    localparam int HeadPadWidth  = FlitDataWidth - XWidth - YWidth - PktWidth;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_e;

    typedef struct packed {
        logic [FlitWidth-1:0] fdata;
        logic                 valid;
        logic [VcWidth-1:0]   vc_id;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;

    typedef struct packed {
        flit_type_e            ftype;
        logic [XWidth-1:0]     x_dest;
        logic [YWidth-1:0]     y_dest;
        logic [PktWidth-1:0]   pkt_size;
        logic [HeadPadWidth-1:0] zeros;
    } s_head_flit_t;

    function automatic logic [FlitWidth-1:0] make_head_flit(
        input logic [XWidth-1:0]   x_dest,
        input logic [YWidth-1:0]   y_dest,
        input logic [PktWidth-1:0] pkt_size
    );
        s_head_flit_t head;
        head.ftype    = HEAD_FLIT;
        head.x_dest   = x_dest;
        head.y_dest   = y_dest;
        head.pkt_size = pkt_size;
        head.zeros    = '0;
        return head;
    endfunction

endpackage

// File: rtl/local_flit_injector.sv
// Packetizer driving a router local input: head flit from a descriptor, then body/tail
// flits from payload words, with self-addressed descriptors drained and flagged.
module local_flit_injector
    import local_flit_injector_pkg::*;
#(
    parameter logic [XWidth-1:0] ROUTER_X_ID = '0,
    parameter logic [YWidth-1:0] ROUTER_Y_ID = '0
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     msg_valid_i,
    output logic                     msg_ready_o,
    input  logic [XWidth-1:0]        msg_x_dest_i,
    input  logic [YWidth-1:0]        msg_y_dest_i,
    input  logic [PktWidth-1:0]      msg_len_i,
    input  logic [VcWidth-1:0]       msg_vc_i,
    input  logic                     pld_valid_i,
    output logic                     pld_ready_o,
    input  logic [FlitDataWidth-1:0] pld_data_i,
    output s_flit_req_t              flit_req_o,
    input  s_flit_resp_t             flit_resp_i,
    output logic                     err_self_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam logic [PktWidth-1:0] PktOne = PktWidth'(1);

    state_e              state_q, state_d;
    s_flit_req_t         flit_q, flit_d;
    logic [PktWidth-1:0] rem_q, rem_d;
    logic [VcWidth-1:0]  vc_q, vc_d;
    logic                err_q, err_d;
    logic                out_free;
    logic                is_self;
    flit_type_e          word_type;

    // The output register can take a new flit when empty or when its flit retires this cycle.
    assign out_free  = !flit_q.valid || flit_resp_i.ready;
    assign is_self   = (msg_x_dest_i == ROUTER_X_ID) && (msg_y_dest_i == ROUTER_Y_ID);
    assign word_type = (rem_q == PktOne) ? TAIL_FLIT : BODY_FLIT;

    // Next-state, output-register and handshake logic.
    always_comb begin
        state_d     = state_q;
        flit_d      = flit_q;
        rem_d       = rem_q;
        vc_d        = vc_q;
        err_d       = 1'b0;
        msg_ready_o = 1'b0;
        pld_ready_o = 1'b0;

        if (flit_q.valid && flit_resp_i.ready) begin
            flit_d.valid = 1'b0;
        end else begin
            flit_d.valid = flit_q.valid;
        end

        case (state_q)
            ST_IDLE: begin
                msg_ready_o = out_free && !arst;
                if (msg_valid_i && out_free) begin
                    rem_d = msg_len_i;
                    vc_d  = msg_vc_i;
                    if (is_self) begin
                        err_d   = 1'b1;
                        state_d = (msg_len_i == '0) ? ST_IDLE : ST_DRAIN;
                    end else begin
                        flit_d.fdata = make_head_flit(msg_x_dest_i, msg_y_dest_i, msg_len_i);
                        flit_d.valid = 1'b1;
                        flit_d.vc_id = msg_vc_i;
                        state_d      = (msg_len_i == '0) ? ST_IDLE : ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                pld_ready_o = out_free && !arst;
                if (pld_valid_i && out_free) begin
                    flit_d.fdata = {word_type, pld_data_i};
                    flit_d.valid = 1'b1;
                    flit_d.vc_id = vc_q;
                    rem_d        = rem_q - PktOne;
                    state_d      = (rem_q == PktOne) ? ST_IDLE : ST_PAYLOAD;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_DRAIN: begin
                pld_ready_o = !arst;
                if (pld_valid_i) begin
                    rem_d   = rem_q - PktOne;
                    state_d = (rem_q == PktOne) ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending flit and abandons the packet.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ST_IDLE;
            flit_q  <= '0;
            rem_q   <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            rem_q   <= rem_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
        end
    end

    assign flit_req_o = flit_q;
    assign err_self_o = err_q;
    assign busy_o     = (state_q != ST_IDLE) || flit_q.valid;

endmodule
